scr1_dp_memory_pipe: RTL and testbench
======================================

# scr1_dp_memory_pipe

Parametrised dual-port synchronous memory with byte-enable writes, selectable read latency (1 or 2 cycles), write-first collision bypass and an optional clear-on-reset sequencer. It replaces the plain dual-port array behind the TCM/IMEM wrappers where deterministic post-reset contents and a registered output stage for timing closure are required. Port A is read-only (fetch side); port B is read/write (load/store side).

## Interface
- SCR1_WIDTH, 32: data word width in bits; multiple of 8.
- SCR1_SIZE, 32'h00010000: memory size in bytes; power of two, at least 2*SCR1_NBYTES.
- SCR1_NBYTES, SCR1_WIDTH/8: byte lanes per word.
- SCR1_RD_LAT, 1: read latency in cycles; legal values 1 or 2.
- SCR1_CLR_ON_RST, 1: 1 = zero the whole array after every reset; 0 = contents undefined, ready immediately.
- Derived: AW = $clog2(SCR1_SIZE), WORDS = SCR1_SIZE/SCR1_NBYTES, BW = $clog2(SCR1_NBYTES).

- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rena  in  1  port A read request.
- addra  in  AW  port A byte address; low BW bits ignored.
- qa  out  SCR1_WIDTH  port A read data.
- qa_vld  out  1  qa carries data for an accepted port A read.
- renb  in  1  port B read request.
- wenb  in  1  port B write request.
- webb  in  SCR1_NBYTES  port B byte enables.
- addrb  in  AW  port B byte address; low BW bits ignored.
- datab  in  SCR1_WIDTH  port B write data.
- qb  out  SCR1_WIDTH  port B read data.
- qb_vld  out  1  qb carries data for an accepted port B read.
- init_done  out  1  1 = array ready and requests accepted.

## Operation
- Word index = addr[AW-1:BW].
- FSM states: CLEAR, READY.
  - Reset with SCR1_CLR_ON_RST=1 enters CLEAR with counter clr_ptr=0.
  - In CLEAR: writes all-zero to word clr_ptr each cycle and increments clr_ptr. After writing word WORDS-1, moves to READY.
  - Reset with SCR1_CLR_ON_RST=0 enters READY directly.
- In CLEAR, all port requests are dropped: no array write, no read, and valid flags stay 0. Requests are not queued.
- In READY:
  - Port B write: only lanes with webb[i]=1 are updated. wenb=1 with webb=0 changes nothing.
  - Reads on both ports may proceed every cycle with independent addresses.
- Collision rule is write-first:
  - A port B read and write to the same word in the same cycle returns the merged word: new bytes on enabled lanes, old bytes elsewhere.
  - A port A read of the word port B writes in the same cycle returns the same merged word.
- qa/qb update only when their read completes. Otherwise they hold their last value.
- Reset asserted mid-operation (in CLEAR or READY): restart from the reset state, restart the clear at word 0, and flush the read pipeline (valid flags to 0). A write already presented in the reset cycle is discarded.

## Timing
- Reset values: qa=0, qb=0, qa_vld=0, qb_vld=0, init_done=0. Reset values of clr_ptr and the FSM are given under Operation.
- init_done:
  - SCR1_CLR_ON_RST=1: rises in the cycle after the last clear write, exactly WORDS+1 cycles after the first clock with rst_n=1. It stays 1 until the next reset.
  - SCR1_CLR_ON_RST=0: 1 from the first clock edge with rst_n=1.
- Read accepted in cycle T (ren=1, init_done=1):
  - SCR1_RD_LAT=1: data and vld valid in cycle T+1.
  - SCR1_RD_LAT=2: data and vld valid in cycle T+2.
  - vld is high for exactly one cycle per accepted read.
- Reads are fully pipelined: back-to-back requests give back-to-back valid cycles with no bubbles.
- A write accepted in cycle T is visible to a read issued in cycle T (bypass) and to any later read.

## Test plan
- Clear after reset, SCR1_SIZE=64, SCR1_WIDTH=32 (16 words): release rst_n -> init_done rises after 17 cycles; reads of word 0 and word 15 return 32'h0; rena/renb pulsed during CLEAR produce no vld.
- Latency: SCR1_RD_LAT=1 then 2. Write 32'hDEADBEEF to addrb=8, then read on both ports -> qa/qb=32'hDEADBEEF with vld at T+1 (or T+2). Four back-to-back reads give four consecutive vld cycles.
- Byte enables: word holds 32'h11223344; write datab=32'hAABBCCDD, webb=4'b0101 -> read returns 32'h11BB33DD. wenb=1, webb=0 -> word unchanged.
- Collision: word holds 32'h0; in one cycle port B writes 32'hCAFEF00D with webb=4'b1100 and both ports read that word -> qa=qb=32'hCAFE0000.
- Reset mid-clear: assert rst_n=0 for 1 cycle when clr_ptr=7 -> vld flags 0 and init_done=0; the full clear reruns, with init_done rising WORDS+1 cycles after release.
- Reset mid-read: SCR1_RD_LAT=2, assert reset one cycle after a read request -> no vld is produced; qa=qb=0.

Source files
------------

// File: rtl/scr1_dp_memory_pipe_if.sv
// Request/response bundle for scr1_dp_memory_pipe: read-only port A, read/write port B.
interface scr1_dp_memory_pipe_if #(
  parameter int unsigned AW     = 16,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NBYTES = WIDTH / 8
);
  logic              rena;
  logic [AW-1:0]     addra;
  logic [WIDTH-1:0]  qa;
  logic              qa_vld;
  logic              renb;
  logic              wenb;
  logic [NBYTES-1:0] webb;
  logic [AW-1:0]     addrb;
  logic [WIDTH-1:0]  datab;
  logic [WIDTH-1:0]  qb;
  logic              qb_vld;
  logic              init_done;

  modport master (
    output rena, addra, renb, wenb, webb, addrb, datab,
    input  qa, qa_vld, qb, qb_vld, init_done
  );

  modport slave (
    input  rena, addra, renb, wenb, webb, addrb, datab,
    output qa, qa_vld, qb, qb_vld, init_done
  );
endinterface

// File: rtl/scr1_dp_memory_pipe.sv
// Dual-port memory with byte-enable writes, 1/2-cycle pipelined reads, write-first
// bypass and an optional zero-fill sequencer that runs after every reset.
module scr1_dp_memory_pipe #(
  parameter int unsigned SCR1_WIDTH      = 32,
  parameter int unsigned SCR1_SIZE       = 32'h00010000,
  parameter int unsigned SCR1_NBYTES     = SCR1_WIDTH / 8,
  parameter int unsigned SCR1_RD_LAT     = 1,
  parameter int unsigned SCR1_CLR_ON_RST = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  scr1_dp_memory_pipe_if.slave mem_bus
);
  localparam int unsigned AW    = $clog2(SCR1_SIZE);
  localparam int unsigned WORDS = SCR1_SIZE / SCR1_NBYTES;
  localparam int unsigned BW    = $clog2(SCR1_NBYTES);
  localparam int unsigned IW    = AW - BW;

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StReady = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [IW-1:0]         clr_ptr_q, clr_ptr_d;
  logic                  clr_we;
  logic                  init_done_q;
  logic [SCR1_WIDTH-1:0] mem_q [WORDS];

  logic [IW-1:0]         idx_a, idx_b;
  logic                  acc_a, acc_b, acc_w;
  logic [SCR1_WIDTH-1:0] merged_a, merged_b;
  logic                  src_a_vld, src_b_vld;
  logic [SCR1_WIDTH-1:0] src_a_data, src_b_data;
  logic [SCR1_WIDTH-1:0] qa_q, qb_q;
  logic                  qa_vld_q, qb_vld_q;
  logic                  unused_addr;

  assign idx_a       = mem_bus.addra[AW-1:BW];
  assign idx_b       = mem_bus.addrb[AW-1:BW];
  assign unused_addr = ^{mem_bus.addra, mem_bus.addrb};

  // Requests are honoured only once the array is ready; a write in a reset cycle is dropped.
  assign acc_a = init_done_q & mem_bus.rena;
  assign acc_b = init_done_q & mem_bus.renb;
  assign acc_w = init_done_q & mem_bus.wenb & rst_n;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    if (state_q == StClear) begin
      clr_we    = 1'b1;
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == IW'(WORDS - 1)) begin
        state_d = StReady;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= (SCR1_CLR_ON_RST != 0) ? StClear : StReady;
      clr_ptr_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      init_done_q <= (state_q == StReady);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_we) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (acc_w) begin
        for (int i = 0; i < SCR1_NBYTES; i++) begin
          if (mem_bus.webb[i]) begin
            mem_q[idx_b][8*i +: 8] <= mem_bus.datab[8*i +: 8];
          end
        end
      end
    end
  end

  // Write-first: enabled lanes of a same-cycle write replace the stored bytes.
  always_comb begin
    merged_a = mem_q[idx_a];
    merged_b = mem_q[idx_b];
    for (int i = 0; i < SCR1_NBYTES; i++) begin
      if (acc_w && mem_bus.webb[i]) begin
        merged_b[8*i +: 8] = mem_bus.datab[8*i +: 8];
        if (idx_a == idx_b) begin
          merged_a[8*i +: 8] = mem_bus.datab[8*i +: 8];
        end
      end
    end
  end

  if (SCR1_RD_LAT == 2) begin : g_lat2
    logic                  s1_va_q, s1_vb_q;
    logic [SCR1_WIDTH-1:0] s1_da_q, s1_db_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_va_q <= 1'b0;
        s1_vb_q <= 1'b0;
        s1_da_q <= '0;
        s1_db_q <= '0;
      end else begin
        s1_va_q <= acc_a;
        s1_vb_q <= acc_b;
        if (acc_a) s1_da_q <= merged_a;
        if (acc_b) s1_db_q <= merged_b;
      end
    end

    assign src_a_vld  = s1_va_q;
    assign src_b_vld  = s1_vb_q;
    assign src_a_data = s1_da_q;
    assign src_b_data = s1_db_q;
  end else begin : g_lat1
    assign src_a_vld  = acc_a;
    assign src_b_vld  = acc_b;
    assign src_a_data = merged_a;
    assign src_b_data = merged_b;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qa_q     <= '0;
      qb_q     <= '0;
      qa_vld_q <= 1'b0;
      qb_vld_q <= 1'b0;
    end else begin
      qa_vld_q <= src_a_vld;
      qb_vld_q <= src_b_vld;
      if (src_a_vld) qa_q <= src_a_data;
      if (src_b_vld) qb_q <= src_b_data;
    end
  end

  assign mem_bus.qa        = qa_q;
  assign mem_bus.qb        = qb_q;
  assign mem_bus.qa_vld    = qa_vld_q;
  assign mem_bus.qb_vld    = qb_vld_q;
  assign mem_bus.init_done = init_done_q;
endmodule

// File: tb/tb_scr1_dp_memory_pipe.sv
// Directed bench: one 16-word instance per read latency, driven with identical stimulus.
module tb_scr1_dp_memory_pipe;
  localparam int unsigned AW = 6;

  logic clk;
  logic rst_n;
  logic rena, renb, wenb;
  logic [AW-1:0] addra, addrb;
  logic [3:0] webb;
  logic [31:0] datab;

  int n_vec = 0;
  int n_err = 0;

  scr1_dp_memory_pipe_if #(.AW(AW), .WIDTH(32), .NBYTES(4)) bus1 ();
  scr1_dp_memory_pipe_if #(.AW(AW), .WIDTH(32), .NBYTES(4)) bus2 ();

  assign bus1.rena = rena;   assign bus2.rena = rena;
  assign bus1.addra = addra; assign bus2.addra = addra;
  assign bus1.renb = renb;   assign bus2.renb = renb;
  assign bus1.wenb = wenb;   assign bus2.wenb = wenb;
  assign bus1.webb = webb;   assign bus2.webb = webb;
  assign bus1.addrb = addrb; assign bus2.addrb = addrb;
  assign bus1.datab = datab; assign bus2.datab = datab;

  scr1_dp_memory_pipe #(
    .SCR1_WIDTH(32), .SCR1_SIZE(64), .SCR1_NBYTES(4), .SCR1_RD_LAT(1), .SCR1_CLR_ON_RST(1)
  ) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .mem_bus (bus1)
  );

  scr1_dp_memory_pipe #(
    .SCR1_WIDTH(32), .SCR1_SIZE(64), .SCR1_NBYTES(4), .SCR1_RD_LAT(2), .SCR1_CLR_ON_RST(1)
  ) u_dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .mem_bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rena;
    logic [5:0]  addra;
    logic        renb;
    logic        wenb;
    logic [3:0]  webb;
    logic [5:0]  addrb;
    logic [31:0] datab;
    logic [31:0] exp_qa;
    logic [31:0] exp_qb;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rena = 0; renb = 0; wenb = 0; webb = '0; addra = '0; addrb = '0; datab = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Counts edges after reset release until bus1.init_done; optionally pulses reads meanwhile.
  task automatic wait_init(input bit pulse, output int cyc, output bit seen_vld);
    cyc = 0;
    seen_vld = 0;
    while (cyc < 100) begin
      idle();
      if (pulse && cyc < 10) begin
        rena = 1; renb = 1; addra = 6'd0; addrb = 6'd60;
      end
      tick();
      cyc++;
      if (bus1.qa_vld || bus1.qb_vld || bus2.qa_vld || bus2.qb_vld) seen_vld = 1;
      if (bus1.init_done) break;
    end
    idle();
  endtask

  initial begin
    int  cyc;
    bit  seen;
    logic [5:0] pa1, pb1, pa2, pb2;

    //          rena addra renb wenb webb     addrb  datab          exp_qa         exp_qb
    vecs[0]  = '{0, 6'd0,  0, 1, 4'b1111, 6'd8,  32'hDEADBEEF, 32'h0,         32'h0};
    vecs[1]  = '{1, 6'd8,  1, 0, 4'b0000, 6'd8,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{0, 6'd0,  0, 1, 4'b1111, 6'd4,  32'h11223344, 32'h0,         32'h0};
    vecs[3]  = '{0, 6'd0,  0, 1, 4'b0101, 6'd4,  32'hAABBCCDD, 32'h0,         32'h0};
    vecs[4]  = '{1, 6'd4,  1, 0, 4'b0000, 6'd4,  32'h0,        32'h11BB33DD, 32'h11BB33DD};
    vecs[5]  = '{0, 6'd0,  0, 1, 4'b0000, 6'd4,  32'hFFFFFFFF, 32'h0,         32'h0};
    vecs[6]  = '{1, 6'd4,  1, 0, 4'b0000, 6'd4,  32'h0,        32'h11BB33DD, 32'h11BB33DD};
    vecs[7]  = '{1, 6'd48, 1, 1, 4'b1100, 6'd48, 32'hCAFEF00D, 32'hCAFE0000, 32'hCAFE0000};
    vecs[8]  = '{1, 6'd0,  1, 0, 4'b0000, 6'd60, 32'h0,        32'h0,         32'h0};
    vecs[9]  = '{1, 6'd11, 1, 0, 4'b0000, 6'd7,  32'h0,        32'hDEADBEEF, 32'h11BB33DD};
    vecs[10] = '{1, 6'd2,  1, 1, 4'b1000, 6'd1,  32'h12345678, 32'h12000000, 32'h12000000};
    vecs[11] = '{1, 6'd8,  1, 1, 4'b0011, 6'd48, 32'h0000BEEF, 32'hDEADBEEF, 32'hCAFEBEEF};

    idle();
    rst_n = 0;
    tick();
    tick();
    chk("rst_qa1", bus1.qa, 32'h0);
    chk("rst_qb1", bus1.qb, 32'h0);
    chk("rst_vld1", {30'b0, bus1.qa_vld, bus1.qb_vld}, 32'h0);
    chk("rst_init1", {31'b0, bus1.init_done}, 32'h0);
    chk("rst_qa2", bus2.qa, 32'h0);
    chk("rst_qb2", bus2.qb, 32'h0);
    chk("rst_vld2", {30'b0, bus2.qa_vld, bus2.qb_vld}, 32'h0);
    chk("rst_init2", {31'b0, bus2.init_done}, 32'h0);

    rst_n = 1;
    wait_init(1'b1, cyc, seen);
    chk("clear_cycles", cyc, 32'd17);
    chk("clear_init2", {31'b0, bus2.init_done}, 32'h1);
    chk("clear_no_vld", {31'b0, seen}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      rena = vecs[i].rena; addra = vecs[i].addra;
      renb = vecs[i].renb; wenb = vecs[i].wenb; webb = vecs[i].webb;
      addrb = vecs[i].addrb; datab = vecs[i].datab;
      tick();
      idle();
      chk($sformatf("v%0d_vld_a1", i), {31'b0, bus1.qa_vld}, {31'b0, vecs[i].rena});
      chk($sformatf("v%0d_vld_b1", i), {31'b0, bus1.qb_vld}, {31'b0, vecs[i].renb});
      chk($sformatf("v%0d_early_vld2", i), {30'b0, bus2.qa_vld, bus2.qb_vld}, 32'h0);
      if (vecs[i].rena) chk($sformatf("v%0d_qa1", i), bus1.qa, vecs[i].exp_qa);
      if (vecs[i].renb) chk($sformatf("v%0d_qb1", i), bus1.qb, vecs[i].exp_qb);
      tick();
      chk($sformatf("v%0d_vld_a2", i), {31'b0, bus2.qa_vld}, {31'b0, vecs[i].rena});
      chk($sformatf("v%0d_vld_b2", i), {31'b0, bus2.qb_vld}, {31'b0, vecs[i].renb});
      chk($sformatf("v%0d_vld_drop1", i), {30'b0, bus1.qa_vld, bus1.qb_vld}, 32'h0);
      if (vecs[i].rena) begin
        chk($sformatf("v%0d_qa2", i), bus2.qa, vecs[i].exp_qa);
        chk($sformatf("v%0d_qa1_hold", i), bus1.qa, vecs[i].exp_qa);
      end
      if (vecs[i].renb) chk($sformatf("v%0d_qb2", i), bus2.qb, vecs[i].exp_qb);
    end

    // Four back-to-back reads must produce four consecutive valid cycles.
    pa1 = '0; pb1 = '0; pa2 = '0; pb2 = '0;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 4) begin
        rena = 1; renb = 1; addra = 6'd48; addrb = 6'd4;
      end
      tick();
      pa1[i] = bus1.qa_vld; pb1[i] = bus1.qb_vld;
      pa2[i] = bus2.qa_vld; pb2[i] = bus2.qb_vld;
    end
    idle();
    chk("b2b_vld_a1", {26'b0, pa1}, 32'h0F);
    chk("b2b_vld_b1", {26'b0, pb1}, 32'h0F);
    chk("b2b_vld_a2", {26'b0, pa2}, 32'h1E);
    chk("b2b_vld_b2", {26'b0, pb2}, 32'h1E);
    chk("b2b_qa2", bus2.qa, 32'hCAFEBEEF);
    chk("b2b_qb1", bus1.qb, 32'h11BB33DD);

    // Reset one cycle after a read: the 2-cycle pipe must never deliver it.
    rena = 1; renb = 1; addra = 6'd8; addrb = 6'd8;
    tick();
    idle();
    rst_n = 0;
    tick();
    chk("rdrst_vld2_a", {30'b0, bus2.qa_vld, bus2.qb_vld}, 32'h0);
    chk("rdrst_init", {30'b0, bus1.init_done, bus2.init_done}, 32'h0);
    chk("rdrst_qa1", bus1.qa, 32'h0);
    rst_n = 1;
    tick();
    chk("rdrst_vld2_b", {30'b0, bus2.qa_vld, bus2.qb_vld}, 32'h0);
    chk("rdrst_qa2", bus2.qa, 32'h0);
    chk("rdrst_qb2", bus2.qb, 32'h0);

    // One edge after release clr_ptr is 1; six more bring it to 7, then reset again.
    for (int i = 0; i < 6; i++) tick();
    rst_n = 0;
    tick();
    chk("midclr_vld", {28'b0, bus1.qa_vld, bus1.qb_vld, bus2.qa_vld, bus2.qb_vld}, 32'h0);
    chk("midclr_init", {30'b0, bus1.init_done, bus2.init_done}, 32'h0);
    rst_n = 1;
    wait_init(1'b0, cyc, seen);
    chk("reclear_cycles", cyc, 32'd17);
    chk("reclear_init2", {31'b0, bus2.init_done}, 32'h1);

    // Word 2 held DEADBEEF before the rerun clear; it must now read as zero.
    rena = 1; renb = 1; addra = 6'd8; addrb = 6'd60;
    tick();
    idle();
    chk("post_clr_vld1", {30'b0, bus1.qa_vld, bus1.qb_vld}, 32'h3);
    chk("post_clr_qa1", bus1.qa, 32'h0);
    chk("post_clr_qb1", bus1.qb, 32'h0);
    tick();
    chk("post_clr_vld2", {30'b0, bus2.qa_vld, bus2.qb_vld}, 32'h3);
    chk("post_clr_qa2", bus2.qa, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
